mem_cdb_arbiter: RTL and testbench
==================================

Name: mem_cdb_arbiter

Overview:
- Sits directly downstream of the memory unit, between its CDB-side outputs and the register-file common data bus (CDB).
- The memory unit is fixed-latency and cannot stall, so every MEM writeback is captured in a small FIFO.
- Each cycle, one writeback (ALU or MEM) is arbitrated onto a registered CDB.
- ALU has default priority; a wait counter guarantees MEM forward progress. An almost-full flag lets issue logic throttle new memory instructions.

Parameters:
- DEPTH, 4, MEM writeback FIFO entries (power of 2, >=2).
- MAX_WAIT, 3, consecutive cycles a non-empty FIFO head may lose to ALU before MEM is forced to win (>=1).
- AF_MARGIN, 2, mem_almost_full asserts when count >= DEPTH-AF_MARGIN.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- mem_valid  in  1  MEM writeback valid (memory unit cdb_regwrite)
- mem_warp_ID  in  3  warp of MEM writeback
- mem_reg_addr  in  5  destination register
- mem_mask  in  8  per-thread write mask
- mem_data  in  256  8x32-bit write data
- alu_valid  in  1  ALU writeback request; held stable until granted
- alu_warp_ID  in  3  ALU warp
- alu_reg_addr  in  5  ALU destination
- alu_mask  in  8  ALU mask
- alu_data  in  256  ALU data
- alu_grant  out  1  combinational; ALU request accepted this cycle
- mem_almost_full  out  1  registered-count based throttle to issue
- mem_overflow  out  1  sticky error, a MEM writeback was dropped
- cdb_valid  out  1  CDB write strobe
- cdb_src  out  1  0=ALU, 1=MEM
- cdb_warp_ID  out  3
- cdb_reg_addr  out  5
- cdb_mask  out  8
- cdb_data  out  256

Behaviour:
- Reset (rst=1 at clk edge): FIFO empty, count=0, wait_cnt=0, mem_overflow=0, and all cdb_* outputs = 0. Reset mid-operation discards FIFO contents and any pending winner.
- Push: mem_valid=1 writes {warp,reg,mask,data} at the tail. It is accepted if count<DEPTH, or if count==DEPTH and a pop occurs in the same cycle. Otherwise the entry is dropped and mem_overflow sets, staying set until reset.
- Push and pop in the same cycle: count unchanged; FIFO order is preserved.
- No bypass: a MEM entry becomes eligible for arbitration the cycle after its push. Minimum MEM input-to-cdb_valid latency is 2 cycles.
- mem_req = (count != 0).
- Arbitration (combinational, every cycle):
  - if mem_req and (wait_cnt >= MAX_WAIT or !alu_valid): MEM wins; pop head.
  - else if alu_valid: ALU wins; alu_grant=1.
  - else: no winner.
- alu_grant is 1 only in cycles where ALU wins, which requires alu_valid=1.
- wait_cnt:
  - cleared when MEM wins or the FIFO is empty;
  - incremented (saturating at MAX_WAIT) when mem_req and ALU wins.
- CDB register: on the clock edge following arbitration, cdb_valid=1 with the winner's fields and cdb_src set; otherwise cdb_valid=0. Data fields are don't-care when cdb_valid=0 but must hold their previous value (no X).
- Output latency is 1 cycle from grant/pop.
- mem_almost_full = (count >= DEPTH-AF_MARGIN), derived from the registered count.
- Pointers wrap modulo DEPTH. count width is $clog2(DEPTH+1).
- Starvation bound: the FIFO head reaches the CDB within MAX_WAIT+1 cycles of becoming head.

Test Plan:
- Reset then idle:
  - stimulus: rst=1 for 2 cycles, then all valids 0 for 5 cycles;
  - required: cdb_valid=0, mem_almost_full=0, mem_overflow=0 throughout.
- MEM only:
  - stimulus: mem_valid=1 at cycle 0 with warp 5, reg 7, mask 8'hA5, data 256'h1234; alu_valid=0;
  - required: cdb_valid=1 at cycle 2 with cdb_src=1 and identical fields.
- Contention and starvation:
  - stimulus: alu_valid held at 1 continuously; one MEM entry pushed at cycle 0; MAX_WAIT=3;
  - required: ALU granted on cycles 1, 2, 3; MEM wins cycle 4 (alu_grant=0); cdb_src=1 at cycle 5; ALU resumes winning at cycle 5.
- Fill and almost-full:
  - stimulus: alu_valid=1 continuously (starvation forces MEM through every 4th cycle); push 4 MEM entries back-to-back;
  - required: mem_almost_full=1 once count>=2; FIFO order preserved on CDB (reg 1, 2, 3, 4).
- Overflow:
  - stimulus: with count==4 and no pop that cycle (ALU winning, wait_cnt<MAX_WAIT), push a 5th entry;
  - required: mem_overflow=1 and stays 1; the 5th entry never appears on CDB.
  - stimulus: push at count==4 in a cycle where MEM wins;
  - required: entry accepted, mem_overflow unchanged.
- Reset mid-operation:
  - stimulus: rst=1 with 3 entries queued and alu_valid=1;
  - required: the following cycle cdb_valid=0, count=0, mem_overflow=0; no queued entry is emitted afterwards.

Source files
------------

// File: rtl/mem_cdb_arbiter.sv
// mem_cdb_arbiter: buffers fixed-latency MEM writebacks in a small FIFO and
// arbitrates one writeback per cycle (ALU by default, MEM when starving or
// when ALU is idle) onto a registered common data bus.
module mem_cdb_arbiter #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned MAX_WAIT  = 3,
    parameter int unsigned AF_MARGIN = 2
) (
    input  logic         clk,
    input  logic         rst,

    input  logic         mem_valid,
    input  logic [2:0]   mem_warp_ID,
    input  logic [4:0]   mem_reg_addr,
    input  logic [7:0]   mem_mask,
    input  logic [255:0] mem_data,

    input  logic         alu_valid,
    input  logic [2:0]   alu_warp_ID,
    input  logic [4:0]   alu_reg_addr,
    input  logic [7:0]   alu_mask,
    input  logic [255:0] alu_data,

    output logic         alu_grant,
    output logic         mem_almost_full,
    output logic         mem_overflow,

    output logic         cdb_valid,
    output logic         cdb_src,
    output logic [2:0]   cdb_warp_ID,
    output logic [4:0]   cdb_reg_addr,
    output logic [7:0]   cdb_mask,
    output logic [255:0] cdb_data
);

    localparam int unsigned WARP_W   = 3;
    localparam int unsigned REG_W    = 5;
    localparam int unsigned MASK_W   = 8;
    localparam int unsigned DATA_W   = 256;
    localparam int unsigned PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W    = $clog2(DEPTH + 1);
    localparam int unsigned WAIT_W   = $clog2(MAX_WAIT + 1);
    localparam int unsigned AF_LEVEL = (AF_MARGIN >= DEPTH) ? 0 : (DEPTH - AF_MARGIN);

    localparam logic       SRC_ALU = 1'b0;
    localparam logic       SRC_MEM = 1'b1;

    typedef struct packed {
        logic [WARP_W-1:0] warp_id;
        logic [REG_W-1:0]  reg_addr;
        logic [MASK_W-1:0] mask;
        logic [DATA_W-1:0] data;
    } wb_t;

    // FIFO storage and bookkeeping
    wb_t               fifo_q [DEPTH];
    logic [PTR_W-1:0]  head_q;
    logic [PTR_W-1:0]  tail_q;
    logic [CNT_W-1:0]  count_q;
    logic [WAIT_W-1:0] wait_q;

    // Registered CDB payload
    wb_t               cdb_wb_q;

    // Combinational arbitration and next-state signals
    wb_t               mem_entry;
    wb_t               alu_entry;
    wb_t               head_entry;
    logic              mem_req;
    logic              wait_expired;
    logic              mem_win;
    logic              alu_win;
    logic              fifo_full;
    logic              push_ok;
    logic              push_drop;
    logic [PTR_W-1:0]  head_nxt;
    logic [PTR_W-1:0]  tail_nxt;
    logic [CNT_W-1:0]  count_nxt;
    logic [WAIT_W-1:0] wait_nxt;

    assign mem_entry  = '{warp_id: mem_warp_ID, reg_addr: mem_reg_addr,
                          mask: mem_mask, data: mem_data};
    assign alu_entry  = '{warp_id: alu_warp_ID, reg_addr: alu_reg_addr,
                          mask: alu_mask, data: alu_data};
    assign head_entry = fifo_q[head_q];

    // Arbitration: MEM wins when ALU is idle or the FIFO head has waited long enough
    always_comb begin
        mem_req      = (count_q != '0);
        wait_expired = (wait_q >= WAIT_W'(MAX_WAIT));
        mem_win      = 1'b0;
        alu_win      = 1'b0;
        if (mem_req && (wait_expired || !alu_valid)) begin
            mem_win = 1'b1;
        end else if (alu_valid) begin
            alu_win = 1'b1;
        end
    end

    assign alu_grant = alu_win;

    // FIFO push/pop, occupancy and starvation counter next-state
    always_comb begin
        fifo_full = (count_q == CNT_W'(DEPTH));
        push_ok   = mem_valid && (!fifo_full || mem_win);
        push_drop = mem_valid && !push_ok;
        head_nxt  = head_q;
        tail_nxt  = tail_q;
        count_nxt = count_q;
        wait_nxt  = wait_q;

        if (mem_win) begin
            head_nxt = head_q + PTR_W'(1);
        end
        if (push_ok) begin
            tail_nxt = tail_q + PTR_W'(1);
        end

        case ({push_ok, mem_win})
            2'b10:   count_nxt = count_q + CNT_W'(1);
            2'b01:   count_nxt = count_q - CNT_W'(1);
            default: count_nxt = count_q;
        endcase

        if (mem_win || !mem_req) begin
            wait_nxt = '0;
        end else if (alu_win && !wait_expired) begin
            wait_nxt = wait_q + WAIT_W'(1);
        end
    end

    // FIFO payload storage; contents are only meaningful between head and tail
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_q[tail_q] <= mem_entry;
        end
    end

    // Control state: pointers, count, wait counter, throttle and sticky overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q          <= '0;
            tail_q          <= '0;
            count_q         <= '0;
            wait_q          <= '0;
            mem_almost_full <= 1'b0;
            mem_overflow    <= 1'b0;
        end else begin
            head_q          <= head_nxt;
            tail_q          <= tail_nxt;
            count_q         <= count_nxt;
            wait_q          <= wait_nxt;
            mem_almost_full <= (count_nxt >= CNT_W'(AF_LEVEL));
            if (push_drop) begin
                mem_overflow <= 1'b1;
            end
        end
    end

    // CDB register: load the winner, otherwise drop the strobe and hold the fields
    always_ff @(posedge clk) begin
        if (rst) begin
            cdb_valid <= 1'b0;
            cdb_src   <= 1'b0;
            cdb_wb_q  <= '0;
        end else begin
            cdb_valid <= mem_win || alu_win;
            if (mem_win) begin
                cdb_src  <= SRC_MEM;
                cdb_wb_q <= head_entry;
            end else if (alu_win) begin
                cdb_src  <= SRC_ALU;
                cdb_wb_q <= alu_entry;
            end
        end
    end

    assign cdb_warp_ID  = cdb_wb_q.warp_id;
    assign cdb_reg_addr = cdb_wb_q.reg_addr;
    assign cdb_mask     = cdb_wb_q.mask;
    assign cdb_data     = cdb_wb_q.data;

endmodule

// File: tb/tb_mem_cdb_arbiter.sv
// tb_mem_cdb_arbiter: directed scenarios plus random traffic, every cycle
// compared against a queue-based reference model of the arbiter.
module tb_mem_cdb_arbiter;

    localparam int DEPTH     = 4;
    localparam int MAX_WAIT  = 3;
    localparam int AF_MARGIN = 2;

    typedef struct packed {
        logic [2:0]   warp_id;
        logic [4:0]   reg_addr;
        logic [7:0]   mask;
        logic [255:0] data;
    } wb_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         mem_valid;
    logic [2:0]   mem_warp_ID;
    logic [4:0]   mem_reg_addr;
    logic [7:0]   mem_mask;
    logic [255:0] mem_data;
    logic         alu_valid;
    logic [2:0]   alu_warp_ID;
    logic [4:0]   alu_reg_addr;
    logic [7:0]   alu_mask;
    logic [255:0] alu_data;
    logic         alu_grant;
    logic         mem_almost_full;
    logic         mem_overflow;
    logic         cdb_valid;
    logic         cdb_src;
    logic [2:0]   cdb_warp_ID;
    logic [4:0]   cdb_reg_addr;
    logic [7:0]   cdb_mask;
    logic [255:0] cdb_data;

    mem_cdb_arbiter #(
        .DEPTH    (DEPTH),
        .MAX_WAIT (MAX_WAIT),
        .AF_MARGIN(AF_MARGIN)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_valid      (mem_valid),
        .mem_warp_ID    (mem_warp_ID),
        .mem_reg_addr   (mem_reg_addr),
        .mem_mask       (mem_mask),
        .mem_data       (mem_data),
        .alu_valid      (alu_valid),
        .alu_warp_ID    (alu_warp_ID),
        .alu_reg_addr   (alu_reg_addr),
        .alu_mask       (alu_mask),
        .alu_data       (alu_data),
        .alu_grant      (alu_grant),
        .mem_almost_full(mem_almost_full),
        .mem_overflow   (mem_overflow),
        .cdb_valid      (cdb_valid),
        .cdb_src        (cdb_src),
        .cdb_warp_ID    (cdb_warp_ID),
        .cdb_reg_addr   (cdb_reg_addr),
        .cdb_mask       (cdb_mask),
        .cdb_data       (cdb_data)
    );

    always #5 clk = ~clk;

    // Reference model state
    wb_t q[$];
    int  wait_m;
    bit  ovf_m;
    bit  exp_valid;
    bit  exp_src;
    wb_t exp_wb;
    bit  last_grant;

    int  n_checks = 0;
    int  n_pass   = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // One clock cycle: check the combinational grant, advance the model at the
    // edge, then compare all registered outputs on the falling edge.
    task automatic tick();
        bit  mem_win;
        bit  alu_win;
        bit  was_empty;
        int  af_level;
        #1;
        mem_win = (q.size() != 0) && ((wait_m >= MAX_WAIT) || !alu_valid);
        alu_win = !mem_win && alu_valid;
        if (!rst) chk("alu_grant", 256'(alu_grant), 256'(alu_win));
        last_grant = alu_grant;
        @(posedge clk);
        if (rst) begin
            q.delete();
            wait_m    = 0;
            ovf_m     = 1'b0;
            exp_valid = 1'b0;
            exp_src   = 1'b0;
            exp_wb    = '0;
        end else begin
            was_empty = (q.size() == 0);
            if (mem_win) begin
                exp_wb    = q.pop_front();
                exp_valid = 1'b1;
                exp_src   = 1'b1;
            end else if (alu_win) begin
                exp_wb    = {alu_warp_ID, alu_reg_addr, alu_mask, alu_data};
                exp_valid = 1'b1;
                exp_src   = 1'b0;
            end else begin
                exp_valid = 1'b0;
            end
            if (mem_valid) begin
                if (q.size() < DEPTH) q.push_back({mem_warp_ID, mem_reg_addr, mem_mask, mem_data});
                else                  ovf_m = 1'b1;
            end
            if (mem_win || was_empty) wait_m = 0;
            else if (alu_win)         wait_m = (wait_m + 1 > MAX_WAIT) ? MAX_WAIT : wait_m + 1;
        end
        @(negedge clk);
        af_level = DEPTH - AF_MARGIN;
        chk("cdb_valid",       256'(cdb_valid),       256'(exp_valid));
        chk("cdb_src",         256'(cdb_src),         256'(exp_src));
        chk("cdb_warp_ID",     256'(cdb_warp_ID),     256'(exp_wb.warp_id));
        chk("cdb_reg_addr",    256'(cdb_reg_addr),    256'(exp_wb.reg_addr));
        chk("cdb_mask",        256'(cdb_mask),        256'(exp_wb.mask));
        chk("cdb_data",        cdb_data,              exp_wb.data);
        chk("mem_almost_full", 256'(mem_almost_full), 256'(q.size() >= af_level));
        chk("mem_overflow",    256'(mem_overflow),    256'(ovf_m));
    endtask

    task automatic idle_inputs();
        mem_valid    = 1'b0;
        mem_warp_ID  = '0;
        mem_reg_addr = '0;
        mem_mask     = '0;
        mem_data     = '0;
        alu_valid    = 1'b0;
        alu_warp_ID  = '0;
        alu_reg_addr = '0;
        alu_mask     = '0;
        alu_data     = '0;
    endtask

    task automatic set_alu(input logic [4:0] r);
        alu_valid    = 1'b1;
        alu_warp_ID  = 3'd2;
        alu_reg_addr = r;
        alu_mask     = 8'hFF;
        alu_data     = {8{32'hA1B2C3D4}};
    endtask

    task automatic set_mem(input logic [2:0] w, input logic [4:0] r, input logic [7:0] m,
                           input logic [255:0] d);
        mem_valid    = 1'b1;
        mem_warp_ID  = w;
        mem_reg_addr = r;
        mem_mask     = m;
        mem_data     = d;
    endtask

    initial begin
        logic [4:0] order [$];
        bit         grants [6];
        int         mem_emits;
        int         rate;

        // Reset then idle
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) tick();

        // MEM only: two-cycle latency to the CDB
        set_mem(3'd5, 5'd7, 8'hA5, 256'h1234);
        tick();
        chk("memonly_c1_valid", 256'(cdb_valid), 256'(0));
        mem_valid = 1'b0;
        tick();
        chk("memonly_c2_valid", 256'(cdb_valid), 256'(1));
        chk("memonly_c2_src",   256'(cdb_src),   256'(1));
        chk("memonly_c2_reg",   256'(cdb_reg_addr), 256'(7));
        chk("memonly_c2_data",  cdb_data, 256'h1234);
        for (int i = 0; i < 3; i++) tick();

        // Contention and starvation with ALU held valid
        set_alu(5'd9);
        set_mem(3'd1, 5'd3, 8'h0F, 256'hBEEF);
        tick();
        grants[0] = last_grant;
        mem_valid = 1'b0;
        for (int k = 1; k < 6; k++) begin
            tick();
            grants[k] = last_grant;
            if (k == 4) begin
                chk("starve_c5_src", 256'(cdb_src), 256'(1));
                chk("starve_c5_reg", 256'(cdb_reg_addr), 256'(3));
            end
        end
        chk("starve_grant_c1", 256'(grants[1]), 256'(1));
        chk("starve_grant_c2", 256'(grants[2]), 256'(1));
        chk("starve_grant_c3", 256'(grants[3]), 256'(1));
        chk("starve_grant_c4", 256'(grants[4]), 256'(0));
        chk("starve_grant_c5", 256'(grants[5]), 256'(1));
        idle_inputs();
        for (int i = 0; i < 3; i++) tick();

        // Fill, almost-full, accepted push at full with pop, dropped push
        set_alu(5'd31);
        for (int i = 0; i < 6; i++) begin
            set_mem(3'd4, 5'(i + 1), 8'h11, 256'(i + 100));
            tick();
            if (cdb_valid && cdb_src) order.push_back(cdb_reg_addr);
            if (i == 0) chk("fill_af_c1", 256'(mem_almost_full), 256'(0));
            if (i == 1) chk("fill_af_c2", 256'(mem_almost_full), 256'(1));
            if (i == 4) chk("full_pop_push_ovf", 256'(mem_overflow), 256'(0));
            if (i == 5) chk("full_drop_ovf", 256'(mem_overflow), 256'(1));
        end
        mem_valid = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (cdb_valid && cdb_src) order.push_back(cdb_reg_addr);
        end
        chk("fifo_order_len", 256'(order.size()), 256'(5));
        for (int i = 0; i < order.size() && i < 5; i++)
            chk("fifo_order", 256'(order[i]), 256'(i + 1));
        chk("ovf_sticky", 256'(mem_overflow), 256'(1));

        // Reset mid-operation with 3 queued entries
        for (int i = 0; i < 3; i++) begin
            set_mem(3'd6, 5'(i + 20), 8'h22, 256'(i));
            tick();
        end
        mem_valid = 1'b0;
        rst       = 1'b1;
        tick();
        chk("midrst_valid", 256'(cdb_valid), 256'(0));
        chk("midrst_ovf",   256'(mem_overflow), 256'(0));
        chk("midrst_af",    256'(mem_almost_full), 256'(0));
        rst = 1'b0;
        idle_inputs();
        mem_emits = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (cdb_valid && cdb_src) mem_emits++;
        end
        chk("midrst_no_emit", 256'(mem_emits), 256'(0));

        // Random traffic; ALU requests are held until granted
        last_grant = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            rate = ((c / 500) % 2 == 1) ? 55 : 25;
            rst  = ($urandom_range(0, 399) == 0);
            mem_valid    = ($urandom_range(0, 99) < rate);
            mem_warp_ID  = 3'($urandom_range(0, 7));
            mem_reg_addr = 5'($urandom_range(0, 31));
            mem_mask     = 8'($urandom_range(0, 255));
            mem_data     = {$urandom, $urandom, $urandom, $urandom,
                            $urandom, $urandom, $urandom, $urandom};
            if (!alu_valid || last_grant) begin
                alu_valid    = ($urandom_range(0, 99) < 60);
                alu_warp_ID  = 3'($urandom_range(0, 7));
                alu_reg_addr = 5'($urandom_range(0, 31));
                alu_mask     = 8'($urandom_range(0, 255));
                alu_data     = {$urandom, $urandom, $urandom, $urandom,
                                $urandom, $urandom, $urandom, $urandom};
            end
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
